// File: rtl/udp_tx_arb_pkg.sv
// udp_tx_arb_pkg: shared types and header field layout for udp_tx_arbiter.
`default_nettype none

package udp_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2,
      DROP    = 2'd3
   } arb_state_e;

   localparam int UDP_HDR_W = 144;

   // Bit offsets of each field's LSB inside the packed header (MSB first: dscp .. checksum)
   localparam int CHECKSUM_OFF    = 0;
   localparam int LENGTH_OFF      = 16;
   localparam int DEST_PORT_OFF   = 32;
   localparam int SOURCE_PORT_OFF = 48;
   localparam int DEST_IP_OFF     = 64;
   localparam int SOURCE_IP_OFF   = 96;
   localparam int TTL_OFF         = 128;
   localparam int ECN_OFF         = 136;
   localparam int DSCP_OFF        = 138;

   localparam int TIMEOUT_W = 16;

endpackage

`default_nettype wire

// File: rtl/arb_rr_select.sv
// arb_rr_select: combinational first-requester search starting at a rotating pointer.
`default_nettype none

module arb_rr_select #(
   parameter int PORTS       = 2,
   parameter int ROUND_ROBIN = 1,
   parameter int IDX_W       = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [PORTS-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] w_ptr;
   assign w_ptr = (ROUND_ROBIN != 0) ? ptr_i : '0;

   always_comb begin
      int p;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      p       = 0;
      for (int k = 0; k < PORTS; k++) begin
         p = (int'(w_ptr) + k) % PORTS;
         if (!valid_o && req_i[p]) begin
            valid_o  = 1'b1;
            gnt_o[p] = 1'b1;
            idx_o    = IDX_W'(p);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: frame-locked arbiter sharing one UDP TX port among PORTS requesters.
// Optional payload-stall timeout with drop: define UDP_TX_ARB_TIMEOUT_EN.
`default_nettype none

module udp_tx_arbiter
   import udp_tx_arb_pkg::*;
#(
   parameter int PORTS          = 2,
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS-1:0]             s_udp_hdr_valid,
   output logic [PORTS-1:0]             s_udp_hdr_ready,
   input  logic [PORTS*UDP_HDR_W-1:0]   s_udp_hdr,
   input  logic [PORTS*8-1:0]           s_udp_payload_axis_tdata,
   input  logic [PORTS-1:0]             s_udp_payload_axis_tvalid,
   input  logic [PORTS-1:0]             s_udp_payload_axis_tlast,
   input  logic [PORTS-1:0]             s_udp_payload_axis_tuser,
   output logic [PORTS-1:0]             s_udp_payload_axis_tready,
   output logic                         m_udp_hdr_valid,
   input  logic                         m_udp_hdr_ready,
   output logic [UDP_HDR_W-1:0]         m_udp_hdr,
   output logic [7:0]                   m_udp_payload_axis_tdata,
   output logic                         m_udp_payload_axis_tvalid,
   output logic                         m_udp_payload_axis_tlast,
   output logic                         m_udp_payload_axis_tuser,
   input  logic                         m_udp_payload_axis_tready,
   output logic                         grant_valid,
   output logic [$clog2(PORTS)-1:0]     grant_index
);

   localparam int IDX_W = $clog2(PORTS);

   arb_state_e       state_q;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] ptr_q;
   logic [PORTS-1:0] grant_oh_q;
   logic             grant_valid_q;

   logic [UDP_HDR_W-1:0] hdr_arr  [PORTS];
   logic [7:0]           data_arr [PORTS];

   for (genvar i = 0; i < PORTS; i++) begin : g_unpack
      assign hdr_arr[i]  = s_udp_hdr[i*UDP_HDR_W +: UDP_HDR_W];
      assign data_arr[i] = s_udp_payload_axis_tdata[i*8 +: 8];
   end

   logic [PORTS-1:0] sel_oh;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_valid;

   arb_rr_select #(
      .PORTS       (PORTS),
      .ROUND_ROBIN (ROUND_ROBIN),
      .IDX_W       (IDX_W)
   ) u_select (
      .req_i   (s_udp_hdr_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (sel_oh),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   logic w_g_hdr_valid, w_g_tvalid, w_g_tlast, w_fire, w_pay_hs, w_release;
   logic [IDX_W-1:0] w_ptr_next;

   assign w_g_hdr_valid = s_udp_hdr_valid[grant_q];
   assign w_g_tvalid    = s_udp_payload_axis_tvalid[grant_q];
   assign w_g_tlast     = s_udp_payload_axis_tlast[grant_q];
   assign w_ptr_next    = (grant_q == IDX_W'(PORTS-1)) ? '0 : grant_q + IDX_W'(1);

`ifdef UDP_TX_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt_q;
   // Once the limit is hit the forced terminating beat owns the output until accepted
   assign w_fire = (state_q == PAYLOAD) && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));
`else
   assign w_fire = 1'b0;
`endif

   assign w_pay_hs  = (state_q == PAYLOAD) && !w_fire && w_g_tvalid && m_udp_payload_axis_tready;
   assign w_release = (w_pay_hs && w_g_tlast) ||
                      ((state_q == DROP) && w_g_tvalid && w_g_tlast);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         ptr_q         <= '0;
         grant_oh_q    <= '0;
         grant_valid_q <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sel_valid) begin
                  state_q       <= HDR;
                  grant_q       <= sel_idx;
                  grant_oh_q    <= sel_oh;
                  grant_valid_q <= 1'b1;
               end
            end
            HDR: begin
               // Requester withdrew its header: treat as abandoned and re-arbitrate
               if (!w_g_hdr_valid) begin
                  state_q       <= IDLE;
                  grant_oh_q    <= '0;
                  grant_valid_q <= 1'b0;
               end else if (m_udp_hdr_ready) begin
                  state_q <= PAYLOAD;
               end
            end
            PAYLOAD, DROP: begin
               if (w_release) begin
                  state_q       <= IDLE;
                  grant_oh_q    <= '0;
                  grant_valid_q <= 1'b0;
                  ptr_q         <= w_ptr_next;
               end else if (w_fire && m_udp_payload_axis_tready) begin
                  state_q <= DROP;
               end
            end
            default: state_q <= IDLE;
         endcase
`ifdef UDP_TX_ARB_TIMEOUT_EN
         if ((state_q != PAYLOAD) || w_pay_hs) begin
            cnt_q <= '0;
         end else if (!w_g_tvalid && !w_fire) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
         end
`endif
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_index = grant_q;

   always_comb begin
      m_udp_hdr                 = grant_valid_q ? hdr_arr[grant_q] : '0;
      m_udp_hdr_valid           = (state_q == HDR) && w_g_hdr_valid;
      s_udp_hdr_ready           = ((state_q == HDR) && m_udp_hdr_ready) ? grant_oh_q : '0;
      m_udp_payload_axis_tdata  = 8'd0;
      m_udp_payload_axis_tvalid = 1'b0;
      m_udp_payload_axis_tlast  = 1'b0;
      m_udp_payload_axis_tuser  = 1'b0;
      s_udp_payload_axis_tready = '0;
      if (state_q == PAYLOAD) begin
         if (w_fire) begin
            m_udp_payload_axis_tvalid = 1'b1;
            m_udp_payload_axis_tlast  = 1'b1;
            m_udp_payload_axis_tuser  = 1'b1;
         end else begin
            m_udp_payload_axis_tdata  = data_arr[grant_q];
            m_udp_payload_axis_tvalid = w_g_tvalid;
            m_udp_payload_axis_tlast  = w_g_tlast;
            m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser[grant_q];
            s_udp_payload_axis_tready = m_udp_payload_axis_tready ? grant_oh_q : '0;
         end
      end else if (state_q == DROP) begin
         s_udp_payload_axis_tready = grant_oh_q;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed self-checking bench; two DUTs (round robin / fixed priority) share stimulus.
`default_nettype none

module tb_udp_tx_arbiter;
   import udp_tx_arb_pkg::*;

   localparam int P  = 2;
   localparam int HW = 144;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [P-1:0]    hdr_valid;
   logic [P*HW-1:0] hdr;
   logic [P*8-1:0]  tdata;
   logic [P-1:0]    tvalid, tlast, tuser;
   logic            m_hdr_ready, m_tready;

   logic [P-1:0] a_s_hdr_ready, a_s_tready, b_s_hdr_ready, b_s_tready;
   logic         a_m_hdr_valid, b_m_hdr_valid;
   logic [HW-1:0] a_m_hdr, b_m_hdr;
   logic [7:0]   a_tdata, b_tdata;
   logic         a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
   logic         a_gv, b_gv;
   logic [0:0]   a_gi, b_gi;

   udp_tx_arbiter #(.PORTS(P), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(10)) u_rr (
      .clk(clk), .rst(rst),
      .s_udp_hdr_valid(hdr_valid), .s_udp_hdr_ready(a_s_hdr_ready), .s_udp_hdr(hdr),
      .s_udp_payload_axis_tdata(tdata), .s_udp_payload_axis_tvalid(tvalid),
      .s_udp_payload_axis_tlast(tlast), .s_udp_payload_axis_tuser(tuser),
      .s_udp_payload_axis_tready(a_s_tready),
      .m_udp_hdr_valid(a_m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready), .m_udp_hdr(a_m_hdr),
      .m_udp_payload_axis_tdata(a_tdata), .m_udp_payload_axis_tvalid(a_tvalid),
      .m_udp_payload_axis_tlast(a_tlast), .m_udp_payload_axis_tuser(a_tuser),
      .m_udp_payload_axis_tready(m_tready),
      .grant_valid(a_gv), .grant_index(a_gi)
   );

   udp_tx_arbiter #(.PORTS(P), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(10)) u_fp (
      .clk(clk), .rst(rst),
      .s_udp_hdr_valid(hdr_valid), .s_udp_hdr_ready(b_s_hdr_ready), .s_udp_hdr(hdr),
      .s_udp_payload_axis_tdata(tdata), .s_udp_payload_axis_tvalid(tvalid),
      .s_udp_payload_axis_tlast(tlast), .s_udp_payload_axis_tuser(tuser),
      .s_udp_payload_axis_tready(b_s_tready),
      .m_udp_hdr_valid(b_m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready), .m_udp_hdr(b_m_hdr),
      .m_udp_payload_axis_tdata(b_tdata), .m_udp_payload_axis_tvalid(b_tvalid),
      .m_udp_payload_axis_tlast(b_tlast), .m_udp_payload_axis_tuser(b_tuser),
      .m_udp_payload_axis_tready(m_tready),
      .grant_valid(b_gv), .grant_index(b_gi)
   );

   // sel chooses which DUT the source/sink model talks to
   logic sel;
   logic [P-1:0]  w_s_hdr_ready, w_s_tready;
   logic          w_m_hdr_valid, w_tvalid, w_tlast, w_tuser, w_gv;
   logic [HW-1:0] w_m_hdr;
   logic [7:0]    w_tdata;
   logic [0:0]    w_gi;
   assign w_s_hdr_ready = sel ? b_s_hdr_ready : a_s_hdr_ready;
   assign w_s_tready    = sel ? b_s_tready    : a_s_tready;
   assign w_m_hdr_valid = sel ? b_m_hdr_valid : a_m_hdr_valid;
   assign w_m_hdr       = sel ? b_m_hdr       : a_m_hdr;
   assign w_tdata       = sel ? b_tdata       : a_tdata;
   assign w_tvalid      = sel ? b_tvalid      : a_tvalid;
   assign w_tlast       = sel ? b_tlast       : a_tlast;
   assign w_tuser       = sel ? b_tuser       : a_tuser;
   assign w_gv          = sel ? b_gv          : a_gv;
   assign w_gi          = sel ? b_gi          : a_gi;

   int checks = 0;
   int failures = 0;

   int frames_left[P], frame_no[P], beat[P], stall_rem[P], stall_beat[P];
   bit in_pay[P];
   int nbeats, cyc, hdr_hold, hold_cnt, gap_cnt;
   bit toggle_tready, prev_tlast_hs;
   int first_req_cyc, first_mhv_cyc, gv_after_tlast;
   int viol_nongrant, viol_sready, viol_hdr, hdr_stall_cycles;
   int            hdr_log[$];
   logic [HW-1:0] hdr_val_log[$];
   logic [9:0]    beat_log[$];

   function automatic logic [HW-1:0] mk_hdr(input int p, input int f);
      return {6'h2E, 2'b01, 8'd64, 32'hC0A80000 + 32'(p), 32'hC0A800FF,
              16'(f), 16'h1000 + 16'(p), 16'(8 + nbeats), 16'hBEEF};
   endfunction

   function automatic logic [7:0] mk_data(input int p, input int f, input int b);
      logic [7:0] d;
      d[7]   = p[0];
      d[6:4] = f[2:0];
      d[3:0] = b[3:0];
      return d;
   endfunction

   task automatic drive();
      for (int p = 0; p < P; p++) begin
         hdr_valid[p]      = !in_pay[p] && (frames_left[p] > 0);
         hdr[p*HW +: HW]   = mk_hdr(p, frame_no[p]);
         tvalid[p]         = in_pay[p] && !(beat[p] == stall_beat[p] && stall_rem[p] > 0);
         tdata[p*8 +: 8]   = in_pay[p] ? mk_data(p, frame_no[p], beat[p]) : 8'd0;
         tlast[p]          = in_pay[p] && (beat[p] == nbeats);
         tuser[p]          = 1'b0;
      end
      m_tready    = toggle_tready ? cyc[0] : 1'b1;
      m_hdr_ready = (hold_cnt >= hdr_hold);
   endtask

   task automatic init_src();
      for (int p = 0; p < P; p++) begin
         frames_left[p] = 0; frame_no[p] = 0; beat[p] = 0;
         stall_rem[p] = 0; stall_beat[p] = 0; in_pay[p] = 1'b0;
      end
      nbeats = 4; hdr_hold = 0; hold_cnt = 0; gap_cnt = 0;
      toggle_tready = 1'b0; prev_tlast_hs = 1'b0;
      first_req_cyc = -1; first_mhv_cyc = -1; gv_after_tlast = -1;
      viol_nongrant = 0; viol_sready = 0; viol_hdr = 0; hdr_stall_cycles = 0;
      hdr_log.delete(); hdr_val_log.delete(); beat_log.delete();
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      init_src();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step();
      logic [P-1:0] hs_h, hs_p;
      @(negedge clk);
      hs_h = hdr_valid & w_s_hdr_ready;
      hs_p = tvalid & w_s_tready;
      if (first_req_cyc < 0 && |hdr_valid) first_req_cyc = cyc;
      if (first_mhv_cyc < 0 && w_m_hdr_valid) first_mhv_cyc = cyc;
      if (prev_tlast_hs) gv_after_tlast = int'(w_gv);
      prev_tlast_hs = w_tvalid && m_tready && w_tlast;
      if (w_m_hdr_valid && m_hdr_ready) begin
         hdr_log.push_back(int'(w_m_hdr[47:32]) - 32'h1000);
         hdr_val_log.push_back(w_m_hdr);
      end
      if (w_m_hdr_valid && !m_hdr_ready) begin
         hdr_stall_cycles++;
         hold_cnt++;
         if (w_s_hdr_ready != '0) viol_hdr++;
      end
      if (beat_log.size() == 2 && !w_tvalid) gap_cnt++;
      if (w_tvalid && m_tready) beat_log.push_back({w_tuser, w_tlast, w_tdata});
      for (int p = 0; p < P; p++) begin
         if (p != int'(w_gi) && (w_s_tready[p] || w_s_hdr_ready[p])) viol_nongrant++;
         if (w_s_tready[p] && !m_tready) viol_sready++;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < P; p++) begin
         if (in_pay[p] && !tvalid[p] && stall_rem[p] > 0) stall_rem[p]--;
         if (hs_h[p]) begin
            in_pay[p] = 1'b1;
            beat[p]   = 1;
         end else if (hs_p[p]) begin
            if (beat[p] == nbeats) begin
               in_pay[p] = 1'b0;
               frame_no[p]++;
               frames_left[p]--;
            end else begin
               beat[p]++;
            end
         end
      end
      drive();
   endtask

   task automatic run_until(input int nh, input int nb, input int maxc);
      int n = 0;
      while ((hdr_log.size() < nh || beat_log.size() < nb) && n < maxc) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      step();
      checks++;
      if (w_m_hdr_valid !== 1'b0 || w_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valids: hdr_valid=%b tvalid=%b required 0 0", w_m_hdr_valid, w_tvalid);
      end
      checks++;
      if (w_s_hdr_ready !== 2'b00 || w_s_tready !== 2'b00) begin
         failures++;
         $display("FAIL reset_readies: hdr_ready=%b tready=%b required 00 00", w_s_hdr_ready, w_s_tready);
      end
      checks++;
      if (w_gv !== 1'b0 || w_gi !== 1'b0) begin
         failures++;
         $display("FAIL reset_grant: gv=%b gi=%b required 0 0", w_gv, w_gi);
      end
      checks++;
      if (w_m_hdr !== '0 || w_tdata !== 8'd0 || w_tlast !== 1'b0 || w_tuser !== 1'b0) begin
         failures++;
         $display("FAIL reset_data: hdr=%h tdata=%h tlast=%b tuser=%b required all zero",
                  w_m_hdr, w_tdata, w_tlast, w_tuser);
      end
   endtask

   task automatic test_single();
      logic [HW-1:0] exp_hdr;
      logic [9:0]    exp_b;
      int            errs;
      sel = 1'b0;
      do_reset();
      nbeats = 8;
      frames_left[0] = 1;
      drive();
      run_until(1, 8, 100);
      repeat (2) step();
      checks++;
      if (first_mhv_cyc - first_req_cyc != 1) begin
         failures++;
         $display("FAIL single_latency: got %0d cycles required 1", first_mhv_cyc - first_req_cyc);
      end
      exp_hdr = {6'h2E, 2'b01, 8'd64, 32'hC0A80000, 32'hC0A800FF,
                 16'h0000, 16'h1000, 16'd16, 16'hBEEF};
      checks++;
      if (hdr_val_log.size() != 1 || hdr_val_log[0] !== exp_hdr) begin
         failures++;
         $display("FAIL single_hdr: count=%0d got %h required %h", hdr_val_log.size(),
                  (hdr_val_log.size() > 0) ? hdr_val_log[0] : '0, exp_hdr);
      end
      checks++;
      if (hdr_val_log.size() < 1 || hdr_val_log[0][LENGTH_OFF +: 16] !== 16'd16) begin
         failures++;
         $display("FAIL single_length: got %0d required 16",
                  (hdr_val_log.size() > 0) ? hdr_val_log[0][LENGTH_OFF +: 16] : 16'd0);
      end
      checks++;
      if (beat_log.size() != 8) begin
         failures++;
         $display("FAIL single_beat_count: got %0d required 8", beat_log.size());
      end else begin
         errs = 0;
         for (int k = 1; k <= 8; k++) begin
            exp_b = {1'b0, (k == 8), 8'(k)};
            if (beat_log[k-1] !== exp_b) errs++;
         end
         checks++;
         if (errs != 0) begin
            failures++;
            $display("FAIL single_beats: %0d beats wrong, first got %h required 001", errs, beat_log[0]);
         end
      end
      checks++;
      if (gv_after_tlast != 0) begin
         failures++;
         $display("FAIL single_gv_after_tlast: got %0d required 0", gv_after_tlast);
      end
   endtask

   task automatic test_arb(input bit use_fixed, input int exp_order[6], input string name);
      int         errs;
      int         fcnt[P];
      logic [9:0] exp_b;
      sel = use_fixed;
      do_reset();
      nbeats = 4;
      frames_left[0] = 3;
      frames_left[1] = 3;
      drive();
      run_until(6, 24, 500);
      step();
      checks++;
      if (hdr_log.size() != 6 || beat_log.size() != 24) begin
         failures++;
         $display("FAIL %s_counts: hdrs=%0d beats=%0d required 6 24", name, hdr_log.size(), beat_log.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 6; i++) if (hdr_log[i] != exp_order[i]) errs++;
         checks++;
         if (errs != 0) begin
            failures++;
            $display("FAIL %s_order: got %0d,%0d,%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d,%0d,%0d", name,
                     hdr_log[0], hdr_log[1], hdr_log[2], hdr_log[3], hdr_log[4], hdr_log[5],
                     exp_order[0], exp_order[1], exp_order[2], exp_order[3], exp_order[4], exp_order[5]);
         end
         errs = 0;
         fcnt[0] = 0;
         fcnt[1] = 0;
         for (int i = 0; i < 6; i++) begin
            for (int b = 1; b <= 4; b++) begin
               exp_b = {1'b0, (b == 4), mk_data(exp_order[i], fcnt[exp_order[i]], b)};
               if (beat_log[i*4 + b - 1] !== exp_b) errs++;
            end
            fcnt[exp_order[i]]++;
         end
         checks++;
         if (errs != 0) begin
            failures++;
            $display("FAIL %s_beats: %0d beats out of place", name, errs);
         end
      end
      checks++;
      if (viol_nongrant != 0) begin
         failures++;
         $display("FAIL %s_nongrant_ready: got %0d cycles required 0", name, viol_nongrant);
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] exp_b;
      int         errs;
      sel = 1'b0;
      do_reset();
      nbeats = 4;
      frames_left[0] = 1;
      frames_left[1] = 1;
      hdr_hold = 5;
      toggle_tready = 1'b1;
      drive();
      run_until(2, 8, 300);
      step();
      checks++;
      if (hdr_stall_cycles != 5 || viol_hdr != 0) begin
         failures++;
         $display("FAIL bp_hdr_hold: stalled=%0d early_ready=%0d required 5 0", hdr_stall_cycles, viol_hdr);
      end
      checks++;
      if (beat_log.size() != 8) begin
         failures++;
         $display("FAIL bp_beat_count: got %0d required 8", beat_log.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 8; i++) begin
            exp_b = {1'b0, (i % 4 == 3), mk_data(i / 4, 0, i % 4 + 1)};
            if (beat_log[i] !== exp_b) errs++;
         end
         checks++;
         if (errs != 0) begin
            failures++;
            $display("FAIL bp_beats: %0d beats lost, duplicated or reordered", errs);
         end
      end
      checks++;
      if (viol_nongrant != 0 || viol_sready != 0) begin
         failures++;
         $display("FAIL bp_tready: nongrant=%0d ready_without_m=%0d required 0 0", viol_nongrant, viol_sready);
      end
   endtask

   task automatic test_reset_mid();
      int errs;
      sel = 1'b0;
      do_reset();
      nbeats = 8;
      frames_left[0] = 1;
      drive();
      run_until(1, 2, 100);
      @(negedge clk);
      checks++;
      if (w_tvalid !== 1'b1 || w_tdata !== 8'h03) begin
         failures++;
         $display("FAIL rstmid_third_beat: tvalid=%b tdata=%h required 1 03", w_tvalid, w_tdata);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (w_m_hdr_valid !== 1'b0 || w_tvalid !== 1'b0 || w_s_hdr_ready !== 2'b00 ||
          w_s_tready !== 2'b00 || w_gv !== 1'b0 || w_tlast !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_outputs: hv=%b tv=%b hr=%b tr=%b gv=%b tl=%b required all 0",
                  w_m_hdr_valid, w_tvalid, w_s_hdr_ready, w_s_tready, w_gv, w_tlast);
      end
      rst = 1'b0;
      init_src();
      frames_left[1] = 1;
      drive();
      run_until(1, 4, 100);
      errs = 0;
      for (int i = 0; i < 4 && i < beat_log.size(); i++)
         if (beat_log[i] !== {1'b0, (i == 3), mk_data(1, 0, i + 1)}) errs++;
      checks++;
      if (hdr_log.size() != 1 || hdr_log[0] != 1 || beat_log.size() != 4 || errs != 0) begin
         failures++;
         $display("FAIL rstmid_recover: hdrs=%0d beats=%0d bad=%0d required 1 4 0",
                  hdr_log.size(), beat_log.size(), errs);
      end
   endtask

`ifdef UDP_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [9:0] exp_q[$];
      int         errs;
      sel = 1'b0;
      do_reset();
      nbeats = 8;
      frames_left[1] = 1;
      stall_beat[1] = 3;
      stall_rem[1] = 20;
      drive();
      run_until(1, 0, 50);
      frames_left[0] = 1;
      drive();
      run_until(2, 11, 300);
      step();
      exp_q = {10'h081, 10'h082, 10'h300, 10'h001, 10'h002, 10'h003, 10'h004,
               10'h005, 10'h006, 10'h007, 10'h108};
      checks++;
      if (gap_cnt != 10) begin
         failures++;
         $display("FAIL timeout_gap: got %0d idle cycles required 10", gap_cnt);
      end
      errs = 0;
      for (int i = 0; i < 11 && i < beat_log.size(); i++) if (beat_log[i] !== exp_q[i]) errs++;
      checks++;
      if (beat_log.size() != 11 || errs != 0) begin
         failures++;
         $display("FAIL timeout_beats: count=%0d bad=%0d required 11 0", beat_log.size(), errs);
      end
      checks++;
      if (hdr_log.size() != 2 || hdr_log[0] != 1 || hdr_log[1] != 0) begin
         failures++;
         $display("FAIL timeout_order: hdrs=%0d required port 1 then port 0", hdr_log.size());
      end
   endtask
`endif

   initial begin
      int rr_order[6];
      int fp_order[6];
      rr_order = '{0, 1, 0, 1, 0, 1};
      fp_order = '{0, 0, 0, 1, 1, 1};
      cyc = 0;
      sel = 1'b0;
      rst = 1'b1;
      init_src();
      test_reset();
      test_single();
      test_arb(1'b0, rr_order, "rr");
      test_arb(1'b1, fp_order, "fixed");
      test_backpressure();
      test_reset_mid();
`ifdef UDP_TX_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
